uart_8250_rx: RTL and testbench
===============================

UART_8250_RX -- requirements
Module: uart_8250_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of two, 2..64).
REQ-002 SHALL have port CLK_I  input  1  system clock.
REQ-003 SHALL have port RST_I  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port baud_tick_i  input  1  one-cycle enable at 16x baud rate.
REQ-005 SHALL have port rxd_i  input  1  serial line, asynchronous, idle high.
REQ-006 SHALL have port lcr_i  input  8  Line Control Register: [1:0] word length-5, [3] parity enable, [4] even, [5] stick.
REQ-007 SHALL have port fifo_en_i  input  1  FCR[0]; 0 selects single holding register.
REQ-008 SHALL have port rx_clr_i  input  1  FCR[1] pulse; flushes FIFO.
REQ-009 SHALL have port rd_i  input  1  pop strobe (RHR read).
REQ-010 SHALL have port err_clr_i  input  1  LSR read strobe; clears sticky overrun.
REQ-011 SHALL have port dat_o  output  8  head byte, show-ahead.
REQ-012 SHALL have port dr_o  output  1  data ready (LSR[0]).
REQ-013 SHALL have ports oe_o, pe_o, fe_o, bi_o  output  1 each  overrun, parity, framing, break (LSR[1..4]).
REQ-014 SHALL have port level_o  output  7  current FIFO occupancy.

Function
REQ-015 SHALL synchronise rxd_i through two flops resetting to 1.
REQ-016 SHALL implement FSM IDLE, START, DATA, PARITY, STOP with 4-bit tick counter advancing only on baud_tick_i.
REQ-017 IDLE -> START on synchronised low; START samples at count 7: low -> DATA (counter restarts), high -> IDLE (glitch, nothing pushed).
REQ-018 Each later bit SHALL be sampled 16 ticks after previous sample; data LSB first, 5+lcr_i[1:0] bits, unused upper dat bits zero.
REQ-019 PARITY state entered only when lcr_i[3]=1; expected bit = stick ? ~lcr_i[4] : (even ? XOR of data : ~XOR of data); mismatch sets entry PE.
REQ-020 STOP samples one stop bit only; low sets entry FE; data, parity and stop all low sets entry BI and forces data 0.
REQ-021 After STOP sample SHALL push {BI,FE,PE,data} in the same cycle and return to IDLE; if line still low, SHALL wait for high before new start.
REQ-022 lcr_i SHALL be sampled at START-to-DATA transition and held for the frame.
REQ-023 Push when full (occupancy FIFO_DEPTH, or 1 with fifo_en_i=0) SHALL discard new byte and set oe_o; oe_o cleared only by err_clr_i or reset; set wins over clear same cycle.
REQ-024 Simultaneous push and rd_i while full SHALL perform both, no overrun.
REQ-025 rd_i when empty SHALL be ignored; level never underflows; pointers wrap modulo FIFO_DEPTH.
REQ-026 dr_o = level_o != 0; dat_o, pe_o, fe_o, bi_o SHALL reflect head entry, zero when empty; push visible on dr_o the next cycle.
REQ-027 rx_clr_i SHALL empty FIFO in one cycle without aborting a frame in progress; push coincident with rx_clr_i SHALL be retained as sole entry.
REQ-028 fifo_en_i change SHALL flush FIFO as rx_clr_i.

Reset
REQ-029 RST_I low SHALL set FSM IDLE, counter 0, pointers 0, level_o 0, dat_o 0, dr_o/oe_o/pe_o/fe_o/bi_o 0, synchroniser 1.
REQ-030 Reset mid-frame SHALL abandon the frame; no push after release until a fresh start bit.

Structure
REQ-031 State encoding, LCR field positions and entry width (11) SHALL live in shared package uart_8250_pkg.
REQ-032 Storage SHALL be sub-module uart_8250_sync_fifo (push, pop, flush, full, empty, level), reusable for transmit.

Verification
REQ-033 8N1 byte 0xA5 -> dat_o 0xA5, dr_o 1, pe_o/fe_o/bi_o 0, level_o 1.
REQ-034 7E1 (lcr_i 0x1A) byte 0x35 with wrong parity -> dat_o 0x35, pe_o 1; rd_i -> dr_o 0.
REQ-035 Line low 12 frames' time, 8N1 -> one entry, dat_o 0x00, bi_o 1, fe_o 1.
REQ-036 17 bytes, no reads, FIFO_DEPTH 16 -> level_o 16, oe_o 1, head 1st byte; err_clr_i -> oe_o 0.
REQ-037 Low pulse 4 ticks on idle line -> no push, FSM IDLE.
REQ-038 RST_I low at data bit 3 then released -> level_o 0, next full frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_8250_pkg.sv
// rtl/uart_8250_pkg.sv - shared FSM encoding, LCR fields and FIFO entry layout for the 8250 receiver
package uart_8250_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int LCR_WLS_LO = 0;
    localparam int LCR_WLS_HI = 1;
    localparam int LCR_PEN    = 3;
    localparam int LCR_EPS    = 4;
    localparam int LCR_STICK  = 5;

    typedef struct packed {
        logic       bi;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

    // Stick parity transmits the inverse of the even-select bit regardless of data.
    function automatic logic parity_bit(input logic data_xor, input logic even, input logic stick);
        if (stick) return ~even;
        return even ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_8250_sync_fifo.sv
// rtl/uart_8250_sync_fifo.sv - show-ahead synchronous FIFO with flush, shared by receive and transmit paths
module uart_8250_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [6:0]       level_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]  PTR_INC = AW'(1);
    localparam logic [6:0]     L_DEPTH = 7'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [6:0]       r_level;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = pop_i && (r_level != 7'd0);
    assign w_do_push = push_i && ((r_level != L_DEPTH) || w_do_pop);

    assign full_o  = (r_level == L_DEPTH);
    assign empty_o = (r_level == 7'd0);
    assign level_o = r_level;
    assign head_o  = empty_o ? '0 : r_mem[r_rd_ptr];

    // A push landing on a flush survives as the only entry, at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 7'd0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= push_i ? PTR_INC : '0;
            r_level  <= push_i ? 7'd1 : 7'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_INC;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_INC;
            r_level <= r_level + {6'd0, w_do_push} - {6'd0, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (flush_i && push_i)
            r_mem[0] <= push_data_i;
        else if (!flush_i && w_do_push)
            r_mem[r_wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/uart_8250_rx.sv
// rtl/uart_8250_rx.sv - 8250-compatible serial receiver with line-status flags and receive FIFO
module uart_8250_rx
    import uart_8250_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       baud_tick_i,
    input  logic       rxd_i,
    input  logic [7:0] lcr_i,
    input  logic       fifo_en_i,
    input  logic       rx_clr_i,
    input  logic       rd_i,
    input  logic       err_clr_i,
    output logic [7:0] dat_o,
    output logic       dr_o,
    output logic       oe_o,
    output logic       pe_o,
    output logic       fe_o,
    output logic       bi_o,
    output logic [6:0] level_o
);

    logic       r_rxd_meta, r_rxd_sync;
    logic [2:0] r_state;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [1:0] r_wls;
    logic       r_pen, r_eps, r_stick;
    logic       r_pe, r_all_low, r_wait_high;
    logic       r_fifo_en_q, r_oe;

    logic       w_sample, w_last_bit, w_push, w_full, w_flush, w_pop, w_accept;
    logic       w_fifo_full, w_fifo_empty;
    logic [6:0] w_level;
    rx_entry_t  w_entry, w_head;
    logic       w_unused_lcr;

    assign w_unused_lcr = ^{lcr_i[7:6], lcr_i[2]};

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= rxd_i;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    assign w_sample   = baud_tick_i && (r_tick_cnt == 4'd15);
    assign w_last_bit = (r_bit_cnt == ({1'b0, r_wls} + 3'd4));
    assign w_push     = (r_state == ST_STOP) && w_sample;

    assign w_entry.bi   = r_all_low && !r_rxd_sync;
    assign w_entry.fe   = !r_rxd_sync;
    assign w_entry.pe   = r_pe;
    assign w_entry.data = w_entry.bi ? 8'h00 : r_shift;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_wls       <= 2'd0;
            r_pen       <= 1'b0;
            r_eps       <= 1'b0;
            r_stick     <= 1'b0;
            r_pe        <= 1'b0;
            r_all_low   <= 1'b0;
            r_wait_high <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tick_cnt <= 4'd0;
                    if (r_wait_high) begin
                        if (r_rxd_sync) r_wait_high <= 1'b0;
                    end else if (!r_rxd_sync) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: if (baud_tick_i) begin
                    if (r_tick_cnt == 4'd7) begin
                        r_tick_cnt <= 4'd0;
                        if (r_rxd_sync) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                            r_shift   <= 8'h00;
                            r_pe      <= 1'b0;
                            r_all_low <= 1'b1;
                            r_wls     <= lcr_i[LCR_WLS_HI:LCR_WLS_LO];
                            r_pen     <= lcr_i[LCR_PEN];
                            r_eps     <= lcr_i[LCR_EPS];
                            r_stick   <= lcr_i[LCR_STICK];
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                end
                ST_DATA: if (baud_tick_i) begin
                    r_tick_cnt <= r_tick_cnt + 4'd1;
                    if (w_sample) begin
                        r_shift[r_bit_cnt] <= r_rxd_sync;
                        if (r_rxd_sync) r_all_low <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) r_state <= r_pen ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: if (baud_tick_i) begin
                    r_tick_cnt <= r_tick_cnt + 4'd1;
                    if (w_sample) begin
                        r_pe <= (r_rxd_sync != parity_bit(^r_shift, r_eps, r_stick));
                        if (r_rxd_sync) r_all_low <= 1'b0;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: if (baud_tick_i) begin
                    r_tick_cnt <= r_tick_cnt + 4'd1;
                    if (w_sample) begin
                        r_state     <= ST_IDLE;
                        r_wait_high <= !r_rxd_sync;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Holding-register mode is the same FIFO capped at one entry.
    assign w_full   = fifo_en_i ? w_fifo_full : !w_fifo_empty;
    assign w_flush  = rx_clr_i || (fifo_en_i != r_fifo_en_q);
    assign w_pop    = rd_i && !w_fifo_empty && !w_flush;
    assign w_accept = w_push && (w_flush || !w_full || w_pop);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_fifo_en_q <= 1'b0;
            r_oe        <= 1'b0;
        end else begin
            r_fifo_en_q <= fifo_en_i;
            if (w_push && !w_accept)
                r_oe <= 1'b1;
            else if (err_clr_i)
                r_oe <= 1'b0;
        end
    end

    uart_8250_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (CLK_I),
        .rst_n       (RST_I),
        .push_i      (w_accept),
        .push_data_i (w_entry),
        .pop_i       (w_pop),
        .flush_i     (w_flush),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .level_o     (w_level),
        .head_o      (w_head)
    );

    assign dat_o   = w_head.data;
    assign pe_o    = w_head.pe;
    assign fe_o    = w_head.fe;
    assign bi_o    = w_head.bi;
    assign level_o = w_level;
    assign dr_o    = (w_level != 7'd0);
    assign oe_o    = r_oe;

endmodule

// File: tb/tb_uart_8250_rx.sv
// tb/tb_uart_8250_rx.sv - scoreboard testbench for uart_8250_rx
module tb_uart_8250_rx;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic       baud_tick_i = 1'b0;
    logic       rxd_i = 1'b1;
    logic [7:0] lcr_i = 8'h03;
    logic       fifo_en_i = 1'b1;
    logic       rx_clr_i = 1'b0;
    logic       rd_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [7:0] dat_o;
    logic       dr_o, oe_o, pe_o, fe_o, bi_o;
    logic [6:0] level_o;

    int checks = 0;
    int failures = 0;
    logic [10:0] sb[$];
    logic [1:0]  tick_div = 2'd0;

    uart_8250_rx #(.FIFO_DEPTH(16)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .baud_tick_i(baud_tick_i), .rxd_i(rxd_i),
        .lcr_i(lcr_i), .fifo_en_i(fifo_en_i), .rx_clr_i(rx_clr_i), .rd_i(rd_i),
        .err_clr_i(err_clr_i), .dat_o(dat_o), .dr_o(dr_o), .oe_o(oe_o),
        .pe_o(pe_o), .fe_o(fe_o), .bi_o(bi_o), .level_o(level_o)
    );

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) begin
        tick_div    <= tick_div + 2'd1;
        baud_tick_i <= (tick_div == 2'd3);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic bit_time();
        repeat (64) @(negedge CLK_I);
    endtask

    function automatic logic [7:0] mask_data(input logic [7:0] d, input logic [7:0] lcr);
        int n;
        n = 5 + int'(lcr[1:0]);
        return d & (8'hFF >> (8 - n));
    endfunction

    function automatic logic par_bit(input logic [7:0] m, input logic [7:0] lcr);
        int ones;
        ones = $countones(m);
        if (lcr[5]) return !lcr[4];
        if (lcr[4]) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    function automatic logic [10:0] model_entry(input logic [7:0] d, input logic [7:0] lcr, input logic bad);
        return {1'b0, 1'b0, lcr[3] && bad, mask_data(d, lcr)};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [7:0] lcr, input logic bad);
        int n;
        n = 5 + int'(lcr[1:0]);
        lcr_i = lcr;
        rxd_i = 1'b0;
        bit_time();
        for (int i = 0; i < n; i++) begin
            rxd_i = d[i];
            bit_time();
        end
        if (lcr[3]) begin
            rxd_i = par_bit(mask_data(d, lcr), lcr) ^ bad;
            bit_time();
        end
        rxd_i = 1'b1;
        bit_time();
    endtask

    task automatic pulse_rd();
        rd_i = 1'b1;
        @(negedge CLK_I);
        rd_i = 1'b0;
        @(negedge CLK_I);
    endtask

    task automatic test_reset();
        RST_I = 1'b0;
        repeat (5) @(negedge CLK_I);
        checks++; if (level_o !== 7'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_o); end
        checks++; if (dr_o !== 1'b0 || oe_o !== 1'b0) begin failures++; $display("FAIL reset_dr_oe got=%b%b exp=00", dr_o, oe_o); end
        checks++; if (dat_o !== 8'h00 || {bi_o, fe_o, pe_o} !== 3'b000) begin failures++; $display("FAIL reset_head got=%h/%b exp=00/000", dat_o, {bi_o, fe_o, pe_o}); end
        RST_I = 1'b1;
        repeat (5) @(negedge CLK_I);
        checks++; if (dr_o !== 1'b0) begin failures++; $display("FAIL reset_release_dr got=%b exp=0", dr_o); end
    endtask

    task automatic test_8n1();
        logic [10:0] exp;
        logic seen;
        send_frame(8'hA5, 8'h03, 1'b0);
        sb.push_back(model_entry(8'hA5, 8'h03, 1'b0));
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (dr_o === 1'b1) seen = 1'b1;
            else @(negedge CLK_I);
        end
        checks++; if (!seen) begin failures++; $display("FAIL 8n1_dr_wait got=0 exp=1"); end
        exp = sb[0];
        checks++; if (dat_o !== exp[7:0]) begin failures++; $display("FAIL 8n1_dat got=%h exp=%h", dat_o, exp[7:0]); end
        checks++; if ({bi_o, fe_o, pe_o} !== exp[10:8]) begin failures++; $display("FAIL 8n1_flags got=%b exp=%b", {bi_o, fe_o, pe_o}, exp[10:8]); end
        checks++; if (level_o !== 7'(sb.size())) begin failures++; $display("FAIL 8n1_level got=%0d exp=%0d", level_o, sb.size()); end
        pulse_rd();
        void'(sb.pop_front());
        checks++; if (dr_o !== 1'b0 || level_o !== 7'd0) begin failures++; $display("FAIL 8n1_after_rd got=%b/%0d exp=0/0", dr_o, level_o); end
    endtask

    task automatic test_7e1_parity();
        logic [10:0] exp;
        send_frame(8'h35, 8'h1A, 1'b1);
        sb.push_back(model_entry(8'h35, 8'h1A, 1'b1));
        repeat (4) @(negedge CLK_I);
        exp = sb[0];
        checks++; if (dat_o !== exp[7:0]) begin failures++; $display("FAIL 7e1_dat got=%h exp=%h", dat_o, exp[7:0]); end
        checks++; if ({bi_o, fe_o, pe_o} !== exp[10:8]) begin failures++; $display("FAIL 7e1_flags got=%b exp=%b", {bi_o, fe_o, pe_o}, exp[10:8]); end
        pulse_rd();
        void'(sb.pop_front());
        checks++; if (dr_o !== 1'b0) begin failures++; $display("FAIL 7e1_dr_after_rd got=%b exp=0", dr_o); end
    endtask

    task automatic test_break();
        logic [10:0] exp;
        lcr_i = 8'h03;
        rxd_i = 1'b0;
        repeat (120) bit_time();
        rxd_i = 1'b1;
        repeat (3) bit_time();
        sb.push_back({1'b1, 1'b1, 1'b0, 8'h00});
        exp = sb[0];
        checks++; if (level_o !== 7'(sb.size())) begin failures++; $display("FAIL break_level got=%0d exp=%0d", level_o, sb.size()); end
        checks++; if (dat_o !== exp[7:0] || {bi_o, fe_o, pe_o} !== exp[10:8]) begin failures++; $display("FAIL break_entry got=%h/%b exp=%h/%b", dat_o, {bi_o, fe_o, pe_o}, exp[7:0], exp[10:8]); end
        pulse_rd();
        void'(sb.pop_front());
    endtask

    task automatic test_glitch();
        rxd_i = 1'b0;
        repeat (16) @(negedge CLK_I);
        rxd_i = 1'b1;
        repeat (3) bit_time();
        checks++; if (level_o !== 7'd0 || dr_o !== 1'b0) begin failures++; $display("FAIL glitch_no_push got=%0d/%b exp=0/0", level_o, dr_o); end
        checks++; if (dut.r_state !== 3'd0) begin failures++; $display("FAIL glitch_fsm_idle got=%0d exp=0", dut.r_state); end
    endtask

    task automatic test_overrun();
        logic [10:0] exp;
        logic [7:0]  d;
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            send_frame(d, 8'h03, 1'b0);
            if (i < 16) sb.push_back(model_entry(d, 8'h03, 1'b0));
            if (i == 15) begin
                checks++; if (oe_o !== 1'b0) begin failures++; $display("FAIL ovr_oe_early got=%b exp=0", oe_o); end
            end
        end
        exp = sb[0];
        checks++; if (level_o !== 7'd16) begin failures++; $display("FAIL ovr_level got=%0d exp=16", level_o); end
        checks++; if (oe_o !== 1'b1) begin failures++; $display("FAIL ovr_oe got=%b exp=1", oe_o); end
        checks++; if (dat_o !== exp[7:0]) begin failures++; $display("FAIL ovr_head got=%h exp=%h", dat_o, exp[7:0]); end
        err_clr_i = 1'b1;
        @(negedge CLK_I);
        err_clr_i = 1'b0;
        checks++; if (oe_o !== 1'b0) begin failures++; $display("FAIL ovr_oe_clr got=%b exp=0", oe_o); end
        while (sb.size() > 0) begin
            exp = sb[0];
            checks++; if ({bi_o, fe_o, pe_o, dat_o} !== exp) begin failures++; $display("FAIL ovr_drain got=%h exp=%h", {bi_o, fe_o, pe_o, dat_o}, exp); end
            pulse_rd();
            void'(sb.pop_front());
        end
        pulse_rd();
        checks++; if (level_o !== 7'd0) begin failures++; $display("FAIL ovr_underflow got=%0d exp=0", level_o); end
    endtask

    task automatic test_single_mode();
        fifo_en_i = 1'b0;
        @(negedge CLK_I);
        send_frame(8'h11, 8'h03, 1'b0);
        sb.push_back(model_entry(8'h11, 8'h03, 1'b0));
        send_frame(8'h22, 8'h03, 1'b0);
        checks++; if (level_o !== 7'd1 || oe_o !== 1'b1) begin failures++; $display("FAIL single_full got=%0d/%b exp=1/1", level_o, oe_o); end
        checks++; if (dat_o !== sb[0][7:0]) begin failures++; $display("FAIL single_head got=%h exp=%h", dat_o, sb[0][7:0]); end
        err_clr_i = 1'b1;
        @(negedge CLK_I);
        err_clr_i = 1'b0;
        pulse_rd();
        void'(sb.pop_front());
        checks++; if (dr_o !== 1'b0 || oe_o !== 1'b0) begin failures++; $display("FAIL single_after_rd got=%b%b exp=00", dr_o, oe_o); end
        send_frame(8'h44, 8'h03, 1'b0);
        fifo_en_i = 1'b1;
        repeat (2) @(negedge CLK_I);
        checks++; if (level_o !== 7'd0) begin failures++; $display("FAIL mode_change_flush got=%0d exp=0", level_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  dv[5] = '{8'h15, 8'hC3, 8'h7E, 8'h9A, 8'hFF};
        logic [7:0]  lv[5] = '{8'h08, 8'h2B, 8'h3B, 8'h1B, 8'h02};
        logic        bv[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [10:0] exp;
        for (int i = 0; i < 5; i++) begin
            send_frame(dv[i], lv[i], bv[i]);
            sb.push_back(model_entry(dv[i], lv[i], bv[i]));
        end
        checks++; if (level_o !== 7'(sb.size())) begin failures++; $display("FAIL b2b_level got=%0d exp=%0d", level_o, sb.size()); end
        while (sb.size() > 0) begin
            exp = sb[0];
            checks++; if ({bi_o, fe_o, pe_o, dat_o} !== exp) begin failures++; $display("FAIL b2b_entry got=%h exp=%h", {bi_o, fe_o, pe_o, dat_o}, exp); end
            pulse_rd();
            void'(sb.pop_front());
        end
    endtask

    task automatic test_flush();
        send_frame(8'h5A, 8'h03, 1'b0);
        checks++; if (level_o !== 7'd1) begin failures++; $display("FAIL flush_pre_level got=%0d exp=1", level_o); end
        rx_clr_i = 1'b1;
        @(negedge CLK_I);
        rx_clr_i = 1'b0;
        checks++; if (level_o !== 7'd0 || dr_o !== 1'b0 || dat_o !== 8'h00) begin failures++; $display("FAIL flush_empty got=%0d/%b/%h exp=0/0/00", level_o, dr_o, dat_o); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  d;
        logic [10:0] exp;
        d = 8'h55;
        lcr_i = 8'h03;
        rxd_i = 1'b0;
        bit_time();
        for (int i = 0; i < 3; i++) begin
            rxd_i = d[i];
            bit_time();
        end
        rxd_i = d[3];
        repeat (32) @(negedge CLK_I);
        RST_I = 1'b0;
        repeat (4) @(negedge CLK_I);
        rxd_i = 1'b1;
        RST_I = 1'b1;
        repeat (8) bit_time();
        checks++; if (level_o !== 7'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", level_o); end
        send_frame(8'h3C, 8'h03, 1'b0);
        sb.push_back(model_entry(8'h3C, 8'h03, 1'b0));
        exp = sb[0];
        checks++; if ({bi_o, fe_o, pe_o, dat_o} !== exp || level_o !== 7'd1) begin failures++; $display("FAIL midrst_frame got=%h/%0d exp=%h/1", {bi_o, fe_o, pe_o, dat_o}, level_o, exp); end
        pulse_rd();
        void'(sb.pop_front());
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1_parity();
        test_break();
        test_glitch();
        test_overrun();
        test_single_mode();
        test_back_to_back();
        test_flush();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
